// File: rtl/bcd_pkg.sv
// Shared types and elaboration helpers for the binary-to-BCD display path.
// Latency: n/a (package only).
// Backpressure: n/a (package only).
package bcd_pkg;

    typedef enum logic {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } state_t;

    localparam int DIGIT_W = 4;

    // Decimal digits needed to show 2^bin_width - 1. A power of two is never
    // a power of ten (above 1), so this equals the digit count of
    // 2^bin_width, i.e. floor(bin_width * log10(2)) + 1. The fixed-point
    // log10(2) approximation is exact for any practical width.
    function automatic int min_digits(input int bin_width);
        return ((bin_width * 30103) / 100000) + 1;
    endfunction

    // Bit counter must hold the value bin_width itself.
    function automatic int cnt_width(input int bin_width);
        return $clog2(bin_width + 1);
    endfunction

endpackage

// File: rtl/bcd_add3.sv
// Double-dabble digit correction: adds 3 to a BCD digit that is 5 or more.
// Latency: combinational, zero cycles.
// Backpressure: none; pure function of its input.
// Ports: din  - scratch BCD digit before the shift
//        dout - corrected digit (4-bit result, carry out dropped)
import bcd_pkg::*;

module bcd_add3 (
    input  logic [DIGIT_W-1:0] din,
    output logic [DIGIT_W-1:0] dout
);

    // For valid digits (0..9) the sum never exceeds 12, so no carry is lost.
    assign dout = (din >= 4'd5) ? (din + 4'd3) : din;

endmodule

// File: rtl/bin_to_bcd_display.sv
// Sequential binary-to-BCD converter (shift-and-add-3) with leading-zero mask.
// Latency: done pulses BIN_WIDTH cycles after the accepted start edge.
// Backpressure: start is only sampled while idle; requests during busy are dropped.
// Ports: clk/reset (async, active-high); start + bin_in request a conversion;
//        busy while converting; done one-cycle pulse when bcd_out/digit_on update;
//        bcd_out holds DIGITS nibbles (digit 0 = LSB), digit_on lights digits.
import bcd_pkg::*;

module bin_to_bcd_display #(
    parameter int BIN_WIDTH = 16,
    parameter int DIGITS    = 5
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       start,
    input  logic [BIN_WIDTH-1:0]       bin_in,
    output logic                       busy,
    output logic                       done,
    output logic [DIGIT_W*DIGITS-1:0]  bcd_out,
    output logic [DIGITS-1:0]          digit_on
);

    localparam int BCD_W = DIGIT_W * DIGITS;
    localparam int CNT_W = cnt_width(BIN_WIDTH);

    // Refuse to build a converter whose result could overflow its digits.
    generate
        if (DIGITS < min_digits(BIN_WIDTH)) begin : g_digits_check
            $error("bin_to_bcd_display: DIGITS too small for BIN_WIDTH");
        end
    endgenerate

    state_t               state_q, state_d;
    logic [BIN_WIDTH-1:0] shift_q;
    logic [BCD_W-1:0]     scratch_q;
    logic [CNT_W-1:0]     cnt_q;

    logic                 load;
    logic                 step;
    logic                 final_shift;

    logic [BCD_W-1:0]     corrected;
    logic [BCD_W-1:0]     next_scratch;
    logic [BIN_WIDTH-1:0] next_shift;
    logic [DIGITS-1:0]    next_on;
    logic                 any_nonzero;

    // One correction unit per digit, applied before every shift.
    genvar g;
    generate
        for (g = 0; g < DIGITS; g++) begin : g_add3
            bcd_add3 u_add3 (
                .din  (scratch_q[g*DIGIT_W +: DIGIT_W]),
                .dout (corrected[g*DIGIT_W +: DIGIT_W])
            );
        end
    endgenerate

    // {scratch, shift} moves left one bit; binary MSB enters scratch LSB.
    assign next_scratch = {corrected[BCD_W-2:0], shift_q[BIN_WIDTH-1]};
    assign next_shift   = {shift_q[BIN_WIDTH-2:0], 1'b0};

    // A digit is lit if it or any more significant digit is nonzero;
    // digit 0 is always lit so a zero value still shows "0".
    always_comb begin
        next_on     = '0;
        any_nonzero = 1'b0;
        for (int i = DIGITS - 1; i >= 0; i--) begin
            any_nonzero = any_nonzero | (next_scratch[i*DIGIT_W +: DIGIT_W] != '0);
            next_on[i]  = any_nonzero | (i == 0);
        end
    end

    // Next-state and control decode.
    always_comb begin
        state_d     = state_q;
        load        = 1'b0;
        step        = 1'b0;
        final_shift = 1'b0;
        case (state_q)
            IDLE: begin
                if (start) begin
                    load    = 1'b1;
                    state_d = SHIFT;
                end
            end
            SHIFT: begin
                step = 1'b1;
                if (cnt_q == CNT_W'(1)) begin
                    final_shift = 1'b1;
                    state_d     = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Datapath and registered outputs.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            shift_q   <= '0;
            scratch_q <= '0;
            cnt_q     <= '0;
            done      <= 1'b0;
            bcd_out   <= '0;
            digit_on  <= DIGITS'(1);
        end else begin
            done <= final_shift;
            if (load) begin
                shift_q   <= bin_in;
                scratch_q <= '0;
                cnt_q     <= CNT_W'(BIN_WIDTH);
            end else if (step) begin
                shift_q   <= next_shift;
                scratch_q <= next_scratch;
                cnt_q     <= cnt_q - CNT_W'(1);
            end
            // Display registers only move on the last shift, so the
            // decoders see a steady value while the next conversion runs.
            if (final_shift) begin
                bcd_out  <= next_scratch;
                digit_on <= next_on;
            end
        end
    end

    assign busy = (state_q == SHIFT);

endmodule

// File: tb/tb_bin_to_bcd_display.sv
module tb_bin_to_bcd_display;

    logic        clk;
    logic        reset;
    logic        start;
    logic [15:0] bin_in;
    logic        busy;
    logic        done;
    logic [19:0] bcd_out;
    logic [4:0]  digit_on;

    int checks;
    int errors;

    bin_to_bcd_display #(
        .BIN_WIDTH (16),
        .DIGITS    (5)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .start    (start),
        .bin_in   (bin_in),
        .busy     (busy),
        .done     (done),
        .bcd_out  (bcd_out),
        .digit_on (digit_on)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Called at a negedge: raise start across one rising edge, then drop it.
    task automatic start_conv(input logic [15:0] v);
        start  = 1'b1;
        bin_in = v;
        @(posedge clk);
        #1;
        start = 1'b0;
    endtask

    // Called just after the start edge. Counts negedges until done (bounded),
    // checks outputs hold their old value meanwhile, then checks the result.
    // inj_at >= 0 pulses start with inj_val at that cycle of the conversion.
    task automatic wait_done(input string tag, input logic [19:0] prev_bcd,
                             input logic [4:0] prev_on, input int inj_at,
                             input logic [15:0] inj_val, input logic [19:0] exp_bcd,
                             input logic [4:0] exp_on);
        int   lat;
        logic stable;
        lat    = 0;
        stable = 1'b1;
        @(negedge clk);
        while (!done && lat < 40) begin
            if (!(busy === 1'b1 && bcd_out === prev_bcd && digit_on === prev_on))
                stable = 1'b0;
            if (lat == inj_at) begin
                start  = 1'b1;
                bin_in = inj_val;
            end else if (lat == inj_at + 1) begin
                start = 1'b0;
            end
            @(negedge clk);
            lat++;
        end
        start = 1'b0;
        check({tag, "_latency"}, lat, 16);
        check({tag, "_held"}, stable, 1);
        check({tag, "_done"}, done, 1);
        check({tag, "_busy_low"}, busy, 0);
        check({tag, "_bcd"}, bcd_out, exp_bcd);
        check({tag, "_digit_on"}, digit_on, exp_on);
    endtask

    initial begin
        logic idle_ok;
        checks = 0;
        errors = 0;
        reset  = 1'b1;
        start  = 1'b0;
        bin_in = '0;

        repeat (3) @(negedge clk);
        check("rst_bcd", bcd_out, 20'h00000);
        check("rst_on", digit_on, 5'b00001);
        reset = 1'b0;
        @(negedge clk);
        check("idle_busy", busy, 0);
        check("idle_done", done, 0);
        check("idle_bcd", bcd_out, 20'h00000);
        check("idle_on", digit_on, 5'b00001);

        idle_ok = 1'b1;
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            if (!(busy === 1'b0 && done === 1'b0 && bcd_out === 20'h00000 && digit_on === 5'b00001))
                idle_ok = 1'b0;
        end
        check("idle_50", idle_ok, 1);

        // 1234
        start_conv(16'd1234);
        check("c1234_busy_up", busy, 1);
        wait_done("c1234", 20'h00000, 5'b00001, -1, 16'd0, 20'h01234, 5'b01111);
        @(negedge clk);
        check("c1234_done_pulse", done, 0);
        check("c1234_hold", bcd_out, 20'h01234);

        // Full-scale
        repeat (2) @(negedge clk);
        start_conv(16'hFFFF);
        wait_done("cffff", 20'h01234, 5'b01111, -1, 16'd0, 20'h65535, 5'b11111);

        // Zero after full-scale
        repeat (3) @(negedge clk);
        start_conv(16'd0);
        wait_done("czero", 20'h65535, 5'b11111, -1, 16'd0, 20'h00000, 5'b00001);

        // Start while busy is ignored, then start on the done cycle
        repeat (2) @(negedge clk);
        start_conv(16'd1234);
        wait_done("cign", 20'h00000, 5'b00001, 5, 16'd999, 20'h01234, 5'b01111);
        start_conv(16'd999);
        check("cchain_done_low", done, 0);
        check("cchain_busy_up", busy, 1);
        wait_done("c999", 20'h01234, 5'b01111, -1, 16'd0, 20'h00999, 5'b00111);

        // Asynchronous reset mid-conversion
        repeat (2) @(negedge clk);
        start_conv(16'd500);
        repeat (8) @(negedge clk);
        #2;
        reset = 1'b1;
        #1;
        check("arst_busy", busy, 0);
        check("arst_done", done, 0);
        check("arst_bcd", bcd_out, 20'h00000);
        check("arst_on", digit_on, 5'b00001);
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        check("arst_idle", busy, 0);
        start_conv(16'd42);
        wait_done("c42", 20'h00000, 5'b00001, -1, 16'd0, 20'h00042, 5'b00011);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/bin_to_bcd_display.md
Name: bin_to_bcd_display

Overview:
- Sequential binary-to-BCD converter using shift-and-add-3 (double-dabble), one bit per clock.
- Sits directly upstream of the per-digit seven-segment decoders. It converts a binary count, such as iteration or frame counts, into decimal digit nibbles.
- Each result nibble drives one decoder instance.
- Result and leading-zero mask are held stable while the next conversion runs, so the display never flickers.

Parameters:
- BIN_WIDTH, 16, width of the binary input.
- DIGITS, 5, number of BCD output digits. Must satisfy 10^DIGITS > 2^BIN_WIDTH - 1; elaboration fails otherwise.

Ports:
- clk  input  1  single system clock, all state on rising edge.
- reset  input  1  asynchronous, active-high reset.
- start  input  1  request conversion of bin_in; sampled only in IDLE.
- bin_in  input  BIN_WIDTH  binary value, captured on the accepted start edge.
- busy  output  1  conversion in progress.
- done  output  1  one-cycle pulse: bcd_out/digit_on just updated.
- bcd_out  output  4*DIGITS  digit i at bits [4i+3:4i], digit 0 = least significant; each digit 0..9.
- digit_on  output  DIGITS  bit i high if digit i should be lit (leading-zero suppression).

Behaviour:
- Interface (decided): one clock; reset is asynchronous and active-high.
- Reset values: state=IDLE, busy=0, done=0, bcd_out=0, digit_on=1 (digit 0 only). These take effect immediately on assertion of reset, including mid-conversion; the partial result is discarded.
- States: IDLE, SHIFT.
- IDLE:
  - start=1 at edge T: capture bin_in into shift register, clear scratch BCD, load bit counter=BIN_WIDTH, go to SHIFT, busy=1.
  - start=0: remain in IDLE.
- SHIFT, each edge:
  - Every scratch digit >=5 gets +3 (4-bit add, no carry out).
  - Then {scratch, shift} shifts left one bit, MSB of shift entering scratch LSB.
  - Counter decrements.
- Final shift, edge T+BIN_WIDTH:
  - The same edge loads bcd_out with the post-shift scratch and loads digit_on.
  - done=1 for exactly one cycle; busy=0; state=IDLE.
- Latency: done is visible BIN_WIDTH cycles after the start edge (16 by default).
- start while busy=1: ignored, with no effect on the in-flight conversion or on the captured bin_in.
- start during the done-high cycle: accepted (state is IDLE). done deasserts and busy asserts on that edge.
- bcd_out and digit_on hold their previous values throughout SHIFT; they change only on the final-shift edge or on reset.
- digit_on[i] = (digit i != 0) OR (any digit j>i != 0) OR (i==0). It is computed from the final scratch and registered together with bcd_out.
- Value 0 yields bcd_out=0, digit_on=...0001.
- Scratch digits never exceed 9 after correction. No overflow is possible given the parameter constraint.

Decomposition:
- Shared package bcd_pkg:
  - state enum {IDLE, SHIFT};
  - DIGIT_W=4 constant;
  - function min_digits(BIN_WIDTH), used for the elaboration check;
  - counter width $clog2(BIN_WIDTH+1).
- Sub-module bcd_add3: combinational 4-bit digit correction (in>=5 ? in+3 : in). DIGITS instances are generated in the top level.

Test Plan:
- Assert reset, release with start=0 -> bcd_out=0x00000, digit_on=5'b00001, busy=0, done=0; no change over 50 idle cycles.
- start with bin_in=16'd1234 -> busy high for 16 cycles, done pulse exactly 16 cycles after start edge, bcd_out=0x01234, digit_on=5'b01111.
- start with bin_in=16'hFFFF -> bcd_out=0x65535, digit_on=5'b11111.
- bin_in=0 after a previous result of 0x65535 -> bcd_out stays 0x65535 during busy, then 0x00000, digit_on=5'b00001.
- Pulse start again at cycle 5 of a conversion with bin_in=999 -> ignored, first result (1234) produced. Then start on the done cycle with bin_in=999 -> second done 16 cycles later, bcd_out=0x00999, digit_on=5'b00111.
- Assert reset asynchronously (between edges) at cycle 8 of a conversion -> outputs immediately at reset values. After release, a new start with 42 gives bcd_out=0x00042, digit_on=5'b00011 after 16 cycles.
